axis_frame_checker: RTL and testbench
=====================================

# axis_frame_checker

Stream-framing checker that sits between the matrix-input traffic generator and the matrix-multiplier AXI-Stream input port. It parses each packet's header word, counts payload words against the header's byte count and regenerates TLAST from that count. Malformed packets are dropped or truncated, and are counted. A 2-entry skid buffer gives a registered `in_TREADY` and full throughput.

## Interface
- `CNT_W`, default 16: width of the packet and error counters.
- `MARKER`, default 8'hFF: required value of header bits [31:24].
- `clk` input 1: single clock; everything is rising-edge.
- `reset` input 1: synchronous, active-high.
- `in_TDATA` input 32: upstream stream data.
- `in_TVALID` input 1: upstream valid.
- `in_TLAST` input 1: upstream end-of-packet.
- `in_TREADY` output 1: registered ready to upstream.
- `out_TDATA` output 32: stream data to the multiplier.
- `out_TVALID` output 1: valid to the multiplier.
- `out_TLAST` output 1: regenerated end-of-packet.
- `out_TREADY` input 1: ready from the multiplier.
- `pkt_count` output CNT_W: number of packets forwarded with correct framing.
- `err_count` output CNT_W: number of packets with any error.
- `err_hdr`, `err_short`, `err_long` output 1 each: sticky error flags, cleared only by reset.
- `busy` output 1: high while the FSM is outside S_HDR.

## Operation
- Transfers: an input transfer occurs when `in_TVALID & in_TREADY`; an output transfer occurs when `out_TVALID & out_TREADY`.
- Header word: the first word of each packet.
  - Bits [31:24] must equal MARKER.
  - Bits [15:0] hold the payload byte count B. B must be nonzero and satisfy B[1:0]==0.
  - Payload length is N = B>>2 words. Bits [23:16] are ignored.
- FSM states:
  - S_HDR: waits for a word. A valid header is forwarded verbatim, loads `rem`=N and moves to S_PAY.
    - Invalid header: set `err_hdr`, increment `err_count`, do not forward.
    - If `in_TLAST`=1 on that word, stay in S_HDR; otherwise go to S_DROP.
    - A valid header arriving with `in_TLAST`=1: set `err_short`, increment `err_count`, drop the header, stay in S_HDR.
  - S_PAY: forwards each word and decrements `rem`. `out_TLAST` = (`rem`==1). Input TLAST is not forwarded.
    - `rem`==1 and `in_TLAST`=1: correct packet; increment `pkt_count`, go to S_HDR.
    - `rem`==1 and `in_TLAST`=0: set `err_long`, increment `err_count`, go to S_DROP.
    - `rem`>1 and `in_TLAST`=1: forward the word with `out_TLAST`=1 (truncated packet), set `err_short`, increment `err_count`, go to S_HDR.
  - S_DROP: consumes words without forwarding. Returns to S_HDR on an input word with `in_TLAST`=1.
- `rem` is 14 bits wide (maximum N is 16383).
- Counters saturate at all-ones and do not wrap.
- `pkt_count` and `err_count` never both increment for the same packet.

## Timing
- Reset values: `out_TDATA`=0, `out_TVALID`=0, `out_TLAST`=0, `in_TREADY`=0, both counters 0, all error flags 0, `busy`=0. The FSM resets to S_HDR, `rem`=0 and the skid buffer is empty.
- `in_TREADY` rises in the first cycle after `reset` deasserts.
- Latency: a word accepted in cycle t appears on `out_*` in cycle t+1 if the output stage is empty or draining.
- `in_TREADY` is a register. It is 0 exactly when the skid entry is occupied.
- Backpressure: if `out_TREADY` drops, the single in-flight word lands in the skid entry and no data is lost.
- Output stability: while `out_TVALID`=1 and `out_TREADY`=0, `out_TDATA` and `out_TLAST` stay stable.
- Throughput: with `out_TREADY` held at 1, one word per cycle sustained.
- Dropped words do not occupy the buffer. The block accepts them at one per cycle while `in_TREADY`=1.
- Flags and counters update in the cycle after the deciding input transfer.
- Reset asserted mid-packet:
  - The buffer flushes.
  - The next word after reset is treated as a header.
  - Counters and flags return to 0.

## Test plan
- Case 1:
  - Stimulus: header 32'hFF001B90, 1764 words of 1, TLAST on the last payload word, `out_TREADY`=1.
  - Required response: 1765 output words, `out_TLAST` only on word 1765, `pkt_count`=1, no errors, 1 word/cycle after 1-cycle latency.
- Case 2:
  - Stimulus: the case 1 packet immediately followed by header 32'hFF0001F8 and 126 payload words.
  - Required response: `pkt_count`=2, second packet 127 output words, `busy` low for no more than 1 cycle between packets.
- Case 3:
  - Stimulus: header 32'h00001B90 followed by 10 words, TLAST on the 10th.
  - Required response: no output, `err_hdr`=1, `err_count`=1. A following valid 2-word packet (header 32'hFF000004 plus 1 payload word) is forwarded with `pkt_count`=1.
- Case 4:
  - Stimulus: header 32'hFF000010 (N=4) followed by 2 payload words, TLAST on the second.
  - Required response: 3 output words, the last with `out_TLAST`=1, `err_short`=1, `pkt_count`=0.
- Case 5:
  - Stimulus: header 32'hFF000008 (N=2) followed by 5 payload words, TLAST on the fifth.
  - Required response: 3 output words, TLAST on the third, words 4-5 dropped, `err_long`=1.
- Case 6:
  - Stimulus: case 1 traffic with `out_TREADY` toggled by a random 50% pattern, and `reset` pulsed for 1 cycle at payload word 900 of a later packet.
  - Required response: data order is preserved and nothing is lost or duplicated before the reset. After the reset, all outputs return to their reset values and the next packet is parsed from its header.

Source files
------------

// File: rtl/axis_frame_checker.sv
// AXI-Stream framing checker: validates each packet header, regenerates TLAST from the
// header byte count, drops or truncates malformed packets, and counts good and bad packets.
module axis_frame_checker #(
    parameter int         CNT_W  = 16,
    parameter logic [7:0] MARKER = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_TDATA,
    input  logic             in_TVALID,
    input  logic             in_TLAST,
    output logic             in_TREADY,
    output logic [31:0]      out_TDATA,
    output logic             out_TVALID,
    output logic             out_TLAST,
    input  logic             out_TREADY,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_hdr,
    output logic             err_short,
    output logic             err_long,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [13:0]        r_rem;
    logic               r_in_ready;
    logic [31:0]        r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic [31:0]        r_skid_data;
    logic               r_skid_last;
    logic               r_skid_valid;
    logic [CNT_W-1:0]   r_pkt_count;
    logic [CNT_W-1:0]   r_err_count;
    logic               r_err_hdr;
    logic               r_err_short;
    logic               r_err_long;

    logic w_in_xfer;
    logic w_out_free;
    logic w_skid_nxt;
    logic w_hdr_ok;
    logic w_rem_one;
    logic w_fwd;
    logic w_fwd_last;
    logic w_pkt_inc;
    logic w_err_inc;
    logic w_set_hdr;
    logic w_set_short;
    logic w_set_long;
    logic w_load_rem;
    logic w_dec_rem;

    assign w_in_xfer  = in_TVALID & r_in_ready;
    assign w_out_free = ~r_out_valid | out_TREADY;
    assign w_hdr_ok   = (in_TDATA[31:24] == MARKER) && (in_TDATA[15:0] != 16'd0)
                        && (in_TDATA[1:0] == 2'b00);
    assign w_rem_one  = (r_rem == 14'd1);
    // The skid entry holds a word only when a forwarded word meets a stalled output stage.
    assign w_skid_nxt = w_out_free ? 1'b0 : (r_skid_valid | w_fwd);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_HDR;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        if (w_in_xfer) begin
            case (r_state)
                S_HDR:   if (!in_TLAST) w_state_nxt = w_hdr_ok ? S_PAY : S_DROP;
                S_PAY:   if (w_rem_one)     w_state_nxt = in_TLAST ? S_HDR : S_DROP;
                         else if (in_TLAST) w_state_nxt = S_HDR;
                S_DROP:  if (in_TLAST) w_state_nxt = S_HDR;
                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    always_comb begin
        w_fwd       = 1'b0;
        w_fwd_last  = 1'b0;
        w_pkt_inc   = 1'b0;
        w_err_inc   = 1'b0;
        w_set_hdr   = 1'b0;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        w_load_rem  = 1'b0;
        w_dec_rem   = 1'b0;
        if (w_in_xfer) begin
            case (r_state)
                S_HDR: begin
                    if (!w_hdr_ok) begin
                        w_set_hdr = 1'b1;
                        w_err_inc = 1'b1;
                    end else if (in_TLAST) begin
                        w_set_short = 1'b1;
                        w_err_inc   = 1'b1;
                    end else begin
                        w_fwd      = 1'b1;
                        w_load_rem = 1'b1;
                    end
                end
                S_PAY: begin
                    // A truncated packet still gets TLAST on its final forwarded word.
                    w_fwd      = 1'b1;
                    w_fwd_last = w_rem_one | in_TLAST;
                    w_dec_rem  = 1'b1;
                    if (w_rem_one && in_TLAST) begin
                        w_pkt_inc = 1'b1;
                    end else if (w_rem_one) begin
                        w_set_long = 1'b1;
                        w_err_inc  = 1'b1;
                    end else if (in_TLAST) begin
                        w_set_short = 1'b1;
                        w_err_inc   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem        <= 14'd0;
            r_in_ready   <= 1'b0;
            r_out_data   <= 32'd0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_data  <= 32'd0;
            r_skid_last  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_pkt_count  <= '0;
            r_err_count  <= '0;
            r_err_hdr    <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
        end else begin
            if (w_load_rem)     r_rem <= in_TDATA[15:2];
            else if (w_dec_rem) r_rem <= r_rem - 14'd1;

            r_in_ready   <= ~w_skid_nxt;
            r_skid_valid <= w_skid_nxt;
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_data  <= r_skid_data;
                    r_out_last  <= r_skid_last;
                    r_out_valid <= 1'b1;
                end else if (w_fwd) begin
                    r_out_data  <= in_TDATA;
                    r_out_last  <= w_fwd_last;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_fwd) begin
                r_skid_data <= in_TDATA;
                r_skid_last <= w_fwd_last;
            end

            // Counters saturate at all-ones.
            if (w_pkt_inc && (r_pkt_count != {CNT_W{1'b1}})) r_pkt_count <= r_pkt_count + CNT_W'(1);
            if (w_err_inc && (r_err_count != {CNT_W{1'b1}})) r_err_count <= r_err_count + CNT_W'(1);
            if (w_set_hdr)   r_err_hdr   <= 1'b1;
            if (w_set_short) r_err_short <= 1'b1;
            if (w_set_long)  r_err_long  <= 1'b1;
        end
    end

    assign in_TREADY  = r_in_ready;
    assign out_TDATA  = r_out_data;
    assign out_TVALID = r_out_valid;
    assign out_TLAST  = r_out_last;
    assign pkt_count  = r_pkt_count;
    assign err_count  = r_err_count;
    assign err_hdr    = r_err_hdr;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;
    assign busy       = (r_state != S_HDR);

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker: expected output beats are queued as words are
// accepted and compared in order when the DUT hands them downstream.
module tb_axis_frame_checker;

    localparam int CNT_W = 3;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      in_TDATA;
    logic             in_TVALID;
    logic             in_TLAST;
    logic             in_TREADY;
    logic [31:0]      out_TDATA;
    logic             out_TVALID;
    logic             out_TLAST;
    logic             out_TREADY;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;
    logic             err_hdr;
    logic             err_short;
    logic             err_long;
    logic             busy;

    beat_t sb[$];
    int    tlast_cyc[$];
    int    checks    = 0;
    int    errors    = 0;
    int    cyc       = 0;
    int    n_out     = 0;
    int    stalls    = 0;
    int    busy_low  = 0;
    int    acc_cyc   = 0;
    bit    rand_ready = 1'b0;

    axis_frame_checker #(.CNT_W(CNT_W), .MARKER(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TLAST   (in_TLAST),
        .in_TREADY  (in_TREADY),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TLAST  (out_TLAST),
        .out_TREADY (out_TREADY),
        .pkt_count  (pkt_count),
        .err_count  (err_count),
        .err_hdr    (err_hdr),
        .err_short  (err_short),
        .err_long   (err_long),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready changes just after the rising edge, so it is stable at the falling edge.
    initial begin
        out_TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a beat seen valid and ready at the falling edge transfers at the next rising edge.
    initial begin
        beat_t       b;
        bit          stall_seen = 1'b0;
        logic [31:0] stall_d = '0;
        logic        stall_l = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_seen && out_TVALID) begin
                check("hold_data", out_TDATA, stall_d);
                check("hold_last", out_TLAST, stall_l);
            end
            stall_seen = out_TVALID && !out_TREADY;
            stall_d    = out_TDATA;
            stall_l    = out_TLAST;
            if (out_TVALID && out_TREADY) begin
                n_out++;
                if (out_TLAST) tlast_cyc.push_back(cyc);
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    b = sb.pop_front();
                    check("out_data", out_TDATA, b.d);
                    check("out_last", out_TLAST, b.l);
                end
            end
        end
    end

    // Called and returns at a falling edge; queues the expected beat once the word is accepted.
    task automatic send_word(input logic [31:0] d, input logic l, input bit fwd, input bit exp_last);
        int wt = 0;
        in_TDATA  = d;
        in_TLAST  = l;
        in_TVALID = 1'b1;
        while (!in_TREADY) begin
            stalls++;
            wt++;
            if (wt > 200) begin
                $display("FAIL ready_timeout: in_TREADY low for %0d cycles, required high", wt);
                $fatal(1, "in_TREADY never returned");
            end
            @(negedge clk);
        end
        acc_cyc = cyc;
        @(posedge clk);
        if (fwd) sb.push_back('{d, exp_last});
        @(negedge clk);
        in_TVALID = 1'b0;
        if (!busy) busy_low++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        in_TVALID = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_tdata"},  out_TDATA,  0);
        check({tag, "_out_tvalid"}, out_TVALID, 0);
        check({tag, "_out_tlast"},  out_TLAST,  0);
        check({tag, "_in_tready"},  in_TREADY,  0);
        check({tag, "_pkt_count"},  pkt_count,  0);
        check({tag, "_err_count"},  err_count,  0);
        check({tag, "_err_hdr"},    err_hdr,    0);
        check({tag, "_err_short"},  err_short,  0);
        check({tag, "_err_long"},   err_long,   0);
        check({tag, "_busy"},       busy,       0);
    endtask

    initial begin
        int n0;
        int first_acc;
        reset     = 1'b1;
        in_TVALID = 1'b0;
        in_TDATA  = '0;
        in_TLAST  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", in_TREADY, 1);

        // Cases 1 and 2: two back-to-back good packets at full rate.
        stalls   = 0;
        busy_low = 0;
        n0       = n_out;
        send_word(32'hFF001B90, 1'b0, 1'b1, 1'b0);
        first_acc = acc_cyc;
        for (int i = 1; i <= 1764; i++) send_word(32'd1, i == 1764, 1'b1, i == 1764);
        check("c1_pkt_count", pkt_count, 1);
        check("c1_err_count", err_count, 0);
        send_word(32'hFF0001F8, 1'b0, 1'b1, 1'b0);
        check("c2_busy_gap", busy_low, 1);
        for (int i = 1; i <= 126; i++) send_word(32'h200 + i, i == 126, 1'b1, i == 126);
        drain("c12");
        check("c2_pkt_count", pkt_count, 2);
        check("c12_stalls", stalls, 0);
        check("c12_out_words", n_out - n0, 1765 + 127);
        check("c12_tlast_count", tlast_cyc.size(), 2);
        if (tlast_cyc.size() >= 2) begin
            check("c1_last_latency", tlast_cyc[0] - first_acc, 1765);
            check("c2_pkt_span", tlast_cyc[1] - tlast_cyc[0], 127);
        end
        check("c12_err_flags", {err_hdr, err_short, err_long}, 0);

        // Case 3: bad marker is dropped whole; then malformed byte counts; then a good packet.
        do_reset();
        n0 = n_out;
        send_word(32'h00001B90, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) send_word(32'(i), i == 10, 1'b0, 1'b0);
        check("c3_err_hdr", err_hdr, 1);
        check("c3_err_count", err_count, 1);
        send_word(32'hFF000004, 1'b0, 1'b1, 1'b0);
        send_word(32'h0000ABCD, 1'b1, 1'b1, 1'b1);
        drain("c3");
        check("c3_pkt_count", pkt_count, 1);
        check("c3_out_words", n_out - n0, 2);
        send_word(32'hFF000006, 1'b1, 1'b0, 1'b0);
        send_word(32'hFF000000, 1'b1, 1'b0, 1'b0);
        check("c3_bad_len_err_count", err_count, 3);
        check("c3_bad_len_pkt_count", pkt_count, 1);

        // Case 4: packet shorter than its header claims is truncated with TLAST.
        do_reset();
        n0 = n_out;
        send_word(32'hFF000010, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000041, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000042, 1'b1, 1'b1, 1'b1);
        drain("c4");
        check("c4_out_words", n_out - n0, 3);
        check("c4_err_short", err_short, 1);
        check("c4_err_count", err_count, 1);
        check("c4_pkt_count", pkt_count, 0);
        check("c4_err_long", err_long, 0);

        // Case 5: overlong packet is cut at N words and the tail dropped.
        do_reset();
        n0 = n_out;
        send_word(32'hFF000008, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000051, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000052, 1'b0, 1'b1, 1'b1);
        send_word(32'h00000053, 1'b0, 1'b0, 1'b0);
        send_word(32'h00000054, 1'b0, 1'b0, 1'b0);
        send_word(32'h00000055, 1'b1, 1'b0, 1'b0);
        drain("c5");
        check("c5_out_words", n_out - n0, 3);
        check("c5_err_long", err_long, 1);
        check("c5_err_count", err_count, 1);
        send_word(32'hFF000004, 1'b1, 1'b0, 1'b0);
        check("c5_hdr_only_short", err_short, 1);
        check("c5_hdr_only_err_count", err_count, 2);
        send_word(32'hFF000004, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000056, 1'b1, 1'b1, 1'b1);
        drain("c5b");
        check("c5_pkt_count", pkt_count, 1);

        // Packet counter saturation at the narrow bench width.
        do_reset();
        for (int p = 0; p < 9; p++) begin
            send_word(32'hFF000004, 1'b0, 1'b1, 1'b0);
            send_word(32'h300 + p, 1'b1, 1'b1, 1'b1);
        end
        drain("sat");
        check("sat_pkt_count", pkt_count, 7);
        check("sat_err_count", err_count, 0);

        // Case 6: random backpressure, then reset in the middle of a second packet.
        do_reset();
        rand_ready = 1'b1;
        n0 = n_out;
        send_word(32'hFF001B90, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 1764; i++) send_word(32'h1000_0000 + i, i == 1764, 1'b1, i == 1764);
        drain("c6a");
        check("c6a_out_words", n_out - n0, 1765);
        check("c6a_pkt_count", pkt_count, 1);
        send_word(32'hFF001B90, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 900; i++) send_word(32'h2000_0000 + i, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        check("c6_inflight_le2", 32'(sb.size() <= 2), 1);
        @(negedge clk);
        check_reset_values("c6_rst");
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
        check("c6_ready_after_reset", in_TREADY, 1);
        n0 = n_out;
        send_word(32'hFF000008, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000061, 1'b0, 1'b1, 1'b0);
        send_word(32'h00000062, 1'b1, 1'b1, 1'b1);
        drain("c6b");
        check("c6b_out_words", n_out - n0, 3);
        check("c6b_pkt_count", pkt_count, 1);
        check("c6b_err_count", err_count, 0);
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
